// File: rtl/lsp_nb.sv
// Non-blocking load/store pipe: address gen, DEPTH in-flight tracker, in-order writeback; issue->wb 3 cycles min.
// Backpressure: AG stalls on dm_req_ready low or full tracker; head holds while lsp_wb_ready is low.
module lsp_nb #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [XLEN-1:0]   dm_req_addr,
  output logic [XLEN-1:0]   dm_req_wdata,
  output logic [XLEN/8-1:0] dm_req_wmask,
  output logic              dm_req_wen,
  output logic              dm_req_valid,
  input  logic              dm_req_ready,
  input  logic [XLEN-1:0]   dm_resp_rdata,
  input  logic              dm_resp_valid,
  input  logic [XLEN-1:0]   ix_lsp_pc,
  input  logic [XLEN-1:0]   ix_lsp_base,
  input  logic [XLEN-1:0]   ix_lsp_source,
  input  logic [4:0]        ix_lsp_dst,
  input  logic              ix_lsp_wb_en,
  input  logic [11:0]       ix_lsp_offset,
  input  logic              ix_lsp_mem_sign,
  input  logic [1:0]        ix_lsp_mem_width,
  input  logic              ix_lsp_valid,
  output logic              ix_lsp_ready,
  output logic              lsp_ix_mem_busy,
  output logic [XLEN-1:0]   lsp_wb_result,
  output logic [XLEN-1:0]   lsp_wb_pc,
  output logic [4:0]        lsp_wb_dst,
  output logic              lsp_wb_wb_en,
  output logic              lsp_wb_valid,
  input  logic              lsp_wb_ready,
  input  logic              ag_abort,
  output logic              lsp_unaligned_load,
  output logic              lsp_unaligned_store,
  output logic [XLEN-1:0]   lsp_unaligned_epc
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      dst;
    logic            wb_en;
    logic [OW-1:0]   off;
    logic [1:0]      width;
    logic            sign;
  } ent_t;

  logic            ag_vld;
  ent_t            ag_ent;
  ent_t            ent_q [DEPTH];
  logic [XLEN-1:0] res_q [DEPTH];
  logic [DEPTH-1:0] done_q;
  logic [PW-1:0]   head_q, tail_q, cmp_q;
  logic [CW-1:0]   cnt_q, pend_q;

  logic [XLEN-1:0] addr, st_wdata, ld_res, ld_sh, ld_mask;
  logic [NB-1:0]   st_wmask;
  logic            misal, issue_hs, take, full, req_hs, resp_take, wb_free, ld_msb;
  ent_t            cmp_ent;

  always_comb begin
    addr = ix_lsp_base + {{(XLEN-12){ix_lsp_offset[11]}}, ix_lsp_offset};
    misal = 1'b0;
    st_wdata = ix_lsp_source;
    st_wmask = '1;
    case (ix_lsp_mem_width)
      2'd0: begin
        st_wdata = {NB{ix_lsp_source[7:0]}};
        st_wmask = NB'(1'b1) << addr[OW-1:0];
      end
      2'd1: begin
        misal = addr[0];
        st_wdata = {(XLEN/16){ix_lsp_source[15:0]}};
        st_wmask = NB'(2'b11) << addr[OW-1:0];
      end
      2'd2: begin
        misal = addr[1:0] != 2'b00;
        st_wdata = {(XLEN/32){ix_lsp_source[31:0]}};
        st_wmask = NB'(4'hF) << addr[OW-1:0];
      end
      default: misal = (XLEN == 32) || (addr[2:0] != 3'b000);
    endcase
  end

  assign full         = cnt_q == CW'(DEPTH);
  assign dm_req_valid = ag_vld && !full;
  assign req_hs       = dm_req_valid && dm_req_ready;
  assign ix_lsp_ready = !ag_vld || req_hs;
  assign issue_hs     = ix_lsp_valid && ix_lsp_ready;
  assign take         = issue_hs && !ag_abort && !misal;
  assign resp_take    = dm_resp_valid && (pend_q != '0);
  assign wb_free      = lsp_wb_valid && lsp_wb_ready;
  assign lsp_ix_mem_busy = ag_vld || (cnt_q != '0);

  assign lsp_wb_valid  = done_q[head_q];
  assign lsp_wb_result = res_q[head_q];
  assign lsp_wb_pc     = ent_q[head_q].pc;
  assign lsp_wb_dst    = ent_q[head_q].dst;
  assign lsp_wb_wb_en  = ent_q[head_q].wb_en;

  // Lane select by shifting the beat down, then mask and extend to the access width.
  always_comb begin
    cmp_ent = ent_q[cmp_q];
    ld_sh   = dm_resp_rdata >> {cmp_ent.off, 3'b000};
    case (cmp_ent.width)
      2'd0:    begin ld_mask = XLEN'(8'hFF);         ld_msb = ld_sh[7];      end
      2'd1:    begin ld_mask = XLEN'(16'hFFFF);      ld_msb = ld_sh[15];     end
      2'd2:    begin ld_mask = XLEN'(32'hFFFF_FFFF); ld_msb = ld_sh[31];     end
      default: begin ld_mask = '1;                   ld_msb = ld_sh[XLEN-1]; end
    endcase
    ld_res = (ld_sh & ld_mask) | ((!cmp_ent.sign && ld_msb) ? ~ld_mask : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ag_vld              <= 1'b0;
      lsp_unaligned_load  <= 1'b0;
      lsp_unaligned_store <= 1'b0;
      head_q              <= '0;
      tail_q              <= '0;
      cmp_q               <= '0;
      cnt_q               <= '0;
      pend_q              <= '0;
      done_q              <= '0;
    end else begin
      if (take)        ag_vld <= 1'b1;
      else if (req_hs) ag_vld <= 1'b0;
      lsp_unaligned_load  <= issue_hs && !ag_abort && misal && ix_lsp_wb_en;
      lsp_unaligned_store <= issue_hs && !ag_abort && misal && !ix_lsp_wb_en;
      if (req_hs)    tail_q <= tail_q + PW'(1);
      if (resp_take) cmp_q  <= cmp_q + PW'(1);
      if (wb_free)   head_q <= head_q + PW'(1);
      cnt_q  <= cnt_q + CW'(req_hs) - CW'(wb_free);
      pend_q <= pend_q + CW'(req_hs) - CW'(resp_take);
      // Freed head is always a completed entry, so it never aliases the completing one.
      if (wb_free)   done_q[head_q] <= 1'b0;
      if (resp_take) done_q[cmp_q]  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      dm_req_addr  <= addr;
      dm_req_wdata <= st_wdata;
      dm_req_wmask <= st_wmask;
      dm_req_wen   <= !ix_lsp_wb_en;
      ag_ent       <= '{pc: ix_lsp_pc, dst: ix_lsp_dst, wb_en: ix_lsp_wb_en,
                        off: addr[OW-1:0], width: ix_lsp_mem_width, sign: ix_lsp_mem_sign};
    end
    if (issue_hs && misal) lsp_unaligned_epc <= ix_lsp_pc;
    if (req_hs)    ent_q[tail_q] <= ag_ent;
    if (resp_take) res_q[cmp_q]  <= cmp_ent.wb_en ? ld_res : '0;
  end

endmodule

// File: tb/tb_lsp_nb.sv
// Scoreboard bench for lsp_nb: directed loads/stores, tracker fill, misalignment, abort and reset.
module tb_lsp_nb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] dm_req_addr, dm_req_wdata;
  logic [7:0]  dm_req_wmask;
  logic        dm_req_wen, dm_req_valid;
  logic        dm_req_ready = 1'b1;
  logic [63:0] dm_resp_rdata = '0;
  logic        dm_resp_valid = 1'b0;
  logic [63:0] ix_lsp_pc = '0, ix_lsp_base = '0, ix_lsp_source = '0;
  logic [4:0]  ix_lsp_dst = '0;
  logic        ix_lsp_wb_en = 1'b0;
  logic [11:0] ix_lsp_offset = '0;
  logic        ix_lsp_mem_sign = 1'b0;
  logic [1:0]  ix_lsp_mem_width = '0;
  logic        ix_lsp_valid = 1'b0;
  logic        ix_lsp_ready, lsp_ix_mem_busy;
  logic [63:0] lsp_wb_result, lsp_wb_pc;
  logic [4:0]  lsp_wb_dst;
  logic        lsp_wb_wb_en, lsp_wb_valid;
  logic        lsp_wb_ready = 1'b1;
  logic        ag_abort = 1'b0;
  logic        lsp_unaligned_load, lsp_unaligned_store;
  logic [63:0] lsp_unaligned_epc;

  lsp_nb #(.XLEN(64), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata), .dm_req_wmask(dm_req_wmask),
    .dm_req_wen(dm_req_wen), .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
    .dm_resp_rdata(dm_resp_rdata), .dm_resp_valid(dm_resp_valid),
    .ix_lsp_pc(ix_lsp_pc), .ix_lsp_base(ix_lsp_base), .ix_lsp_source(ix_lsp_source),
    .ix_lsp_dst(ix_lsp_dst), .ix_lsp_wb_en(ix_lsp_wb_en), .ix_lsp_offset(ix_lsp_offset),
    .ix_lsp_mem_sign(ix_lsp_mem_sign), .ix_lsp_mem_width(ix_lsp_mem_width),
    .ix_lsp_valid(ix_lsp_valid), .ix_lsp_ready(ix_lsp_ready), .lsp_ix_mem_busy(lsp_ix_mem_busy),
    .lsp_wb_result(lsp_wb_result), .lsp_wb_pc(lsp_wb_pc), .lsp_wb_dst(lsp_wb_dst),
    .lsp_wb_wb_en(lsp_wb_wb_en), .lsp_wb_valid(lsp_wb_valid), .lsp_wb_ready(lsp_wb_ready),
    .ag_abort(ag_abort), .lsp_unaligned_load(lsp_unaligned_load),
    .lsp_unaligned_store(lsp_unaligned_store), .lsp_unaligned_epc(lsp_unaligned_epc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr, wdata; logic [7:0] wmask; logic wen; } dm_exp_t;
  typedef struct { logic [63:0] res, pc; logic [4:0] dst; logic wb_en; int cyc; } wb_exp_t;
  typedef struct { logic ld, st; logic [63:0] epc; int cyc; } exc_exp_t;

  dm_exp_t     dm_q[$];
  wb_exp_t     wb_q[$];
  exc_exp_t    exc_q[$];
  logic [63:0] rdata_q[$];
  logic [63:0] resp_q[$];

  int checks = 0, failures = 0, cyc = 0, dm_hs = 0;
  bit resp_en = 1'b1, stray = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @cyc %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=present expected=none @cyc %0d", nm, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: in-order responses, one per cycle, the cycle after the request handshake.
  initial forever begin
    @(posedge clk); #1;
    if (rst) begin
      resp_q.delete();
      dm_resp_valid = 1'b0;
    end else if (resp_en && resp_q.size() > 0) begin
      dm_resp_valid = 1'b1;
      dm_resp_rdata = resp_q.pop_front();
    end else if (stray) begin
      dm_resp_valid = 1'b1;
      dm_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      stray = 1'b0;
    end else begin
      dm_resp_valid = 1'b0;
    end
  end

  initial begin : dm_mon
    bit stalled = 1'b0;
    logic [63:0] h_addr, h_wdata;
    dm_exp_t e;
    forever begin
      @(negedge clk);
      if (rst) stalled = 1'b0;
      else begin
        if (stalled) begin
          chk("dm_hold_valid", 64'(dm_req_valid), 64'd1);
          chk("dm_hold_addr", dm_req_addr, h_addr);
          chk("dm_hold_wdata", dm_req_wdata, h_wdata);
        end
        stalled = dm_req_valid && !dm_req_ready;
        h_addr = dm_req_addr;
        h_wdata = dm_req_wdata;
        if (dm_req_valid && dm_req_ready) begin
          dm_hs++;
          if (dm_q.size() == 0) unexpected("dm_req");
          else begin
            e = dm_q.pop_front();
            chk("dm_addr", dm_req_addr, e.addr);
            chk("dm_wen", 64'(dm_req_wen), 64'(e.wen));
            if (e.wen) begin
              chk("dm_wdata", dm_req_wdata, e.wdata);
              chk("dm_wmask", 64'(dm_req_wmask), 64'(e.wmask));
            end
          end
          resp_q.push_back(rdata_q.size() > 0 ? rdata_q.pop_front() : 64'd0);
        end
      end
    end
  end

  initial begin : wb_mon
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && lsp_wb_valid && lsp_wb_ready) begin
        if (wb_q.size() == 0) unexpected("wb");
        else begin
          e = wb_q.pop_front();
          chk("wb_result", lsp_wb_result, e.res);
          chk("wb_pc", lsp_wb_pc, e.pc);
          chk("wb_dst", 64'(lsp_wb_dst), 64'(e.dst));
          chk("wb_wb_en", 64'(lsp_wb_wb_en), 64'(e.wb_en));
          if (e.cyc >= 0) chk("wb_latency_cyc", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin : exc_mon
    exc_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (lsp_unaligned_load || lsp_unaligned_store)) begin
        if (exc_q.size() == 0) unexpected("unaligned_pulse");
        else begin
          e = exc_q.pop_front();
          chk("unal_load", 64'(lsp_unaligned_load), 64'(e.ld));
          chk("unal_store", 64'(lsp_unaligned_store), 64'(e.st));
          chk("unal_epc", lsp_unaligned_epc, e.epc);
          chk("unal_cyc", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // kind 0: normal access, 1: misaligned (exception), 2: aborted (nothing happens).
  // Called at posedge+1; returns at posedge+1 with valid dropped, so calls chain back-to-back.
  task automatic op(input int kind, input logic [63:0] pc, base, input logic [11:0] off,
                    input logic [1:0] w, input logic sgn, wben, input logic [63:0] src,
                    input logic [4:0] dst, input logic [63:0] rdata, e_addr, e_wdata,
                    input logic [7:0] e_wmask, input logic [63:0] e_res, input bit lat);
    int t = -1;
    ix_lsp_pc = pc; ix_lsp_base = base; ix_lsp_offset = off; ix_lsp_mem_width = w;
    ix_lsp_mem_sign = sgn; ix_lsp_wb_en = wben; ix_lsp_source = src; ix_lsp_dst = dst;
    ag_abort = (kind == 2); ix_lsp_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ix_lsp_ready) begin t = cyc; break; end
      @(posedge clk); #1;
    end
    if (t < 0) $display("FAIL issue_timeout actual=no_handshake expected=handshake pc=%h", pc);
    if (t < 0) begin checks++; failures++; end
    else if (kind == 0) begin
      dm_q.push_back('{addr: e_addr, wdata: e_wdata, wmask: e_wmask, wen: !wben});
      rdata_q.push_back(rdata);
      wb_q.push_back('{res: e_res, pc: pc, dst: dst, wb_en: wben, cyc: lat ? t + 3 : -1});
    end else if (kind == 1) begin
      exc_q.push_back('{ld: wben, st: !wben, epc: pc, cyc: t + 1});
    end
    @(posedge clk); #1;
    ix_lsp_valid = 1'b0; ag_abort = 1'b0;
  endtask

  task automatic flush_reset();
    rst = 1'b1;
    dm_q.delete(); wb_q.delete(); exc_q.delete(); rdata_q.delete();
  endtask

  initial begin
    int hs0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_dm_valid", 64'(dm_req_valid), 64'd0);
    chk("rst_wb_valid", 64'(lsp_wb_valid), 64'd0);
    chk("rst_busy", 64'(lsp_ix_mem_busy), 64'd0);
    chk("rst_ix_ready", 64'(ix_lsp_ready), 64'd1);
    chk("rst_unal", 64'({lsp_unaligned_load, lsp_unaligned_store}), 64'd0);
    @(posedge clk); #1;

    // Loads: lane select and extension, with minimum latency checked on each.
    op(0, 64'h100, 64'h1000, 12'h004, 2'd2, 1'b0, 1'b1, 64'h0, 5'd5, 64'hDEADBEEF_80000001,
       64'h1004, 64'h0, 8'h0, 64'hFFFFFFFF_DEADBEEF, 1'b1);
    idle(4);
    op(0, 64'h104, 64'h1010, 12'hFFF, 2'd0, 1'b0, 1'b1, 64'h0, 5'd6, 64'h81000000_00000000,
       64'h100F, 64'h0, 8'h0, 64'hFFFFFFFF_FFFFFF81, 1'b1);
    idle(4);
    op(0, 64'h108, 64'h1010, 12'hFFF, 2'd0, 1'b1, 1'b1, 64'h0, 5'd7, 64'h81000000_00000000,
       64'h100F, 64'h0, 8'h0, 64'h81, 1'b0);
    op(0, 64'h10C, 64'h1000, 12'h006, 2'd1, 1'b0, 1'b1, 64'h0, 5'd8, 64'h81230000_00000000,
       64'h1006, 64'h0, 8'h0, 64'hFFFFFFFF_FFFF8123, 1'b0);
    op(0, 64'h110, 64'h1000, 12'h006, 2'd1, 1'b1, 1'b1, 64'h0, 5'd9, 64'h81230000_00000000,
       64'h1006, 64'h0, 8'h0, 64'h8123, 1'b0);
    op(0, 64'h114, 64'h1000, 12'h000, 2'd2, 1'b0, 1'b1, 64'h0, 5'd10, 64'h00000000_7FFFFFFF,
       64'h1000, 64'h0, 8'h0, 64'h7FFFFFFF, 1'b0);
    op(0, 64'h118, 64'h2000, 12'h008, 2'd3, 1'b0, 1'b1, 64'h0, 5'd11, 64'h01234567_89ABCDEF,
       64'h2008, 64'h0, 8'h0, 64'h01234567_89ABCDEF, 1'b0);

    // Stores: replicated data, lane masks, zero result with wb_en low.
    op(0, 64'h120, 64'h2000, 12'h002, 2'd1, 1'b0, 1'b0, 64'h1234, 5'd1, 64'h0,
       64'h2002, 64'h12341234_12341234, 8'h0C, 64'h0, 1'b1);
    op(0, 64'h124, 64'h3010, 12'hFFC, 2'd2, 1'b0, 1'b0, 64'h11112222_CAFEBABE, 5'd2, 64'h0,
       64'h300C, 64'hCAFEBABE_CAFEBABE, 8'hF0, 64'h0, 1'b0);
    op(0, 64'h128, 64'h3010, 12'h008, 2'd3, 1'b0, 1'b0, 64'h01020304_05060708, 5'd3, 64'h0,
       64'h3018, 64'h01020304_05060708, 8'hFF, 64'h0, 1'b0);
    idle(6);

    // Memory back-pressure on a store: request must hold stable.
    dm_req_ready = 1'b0;
    op(0, 64'h12C, 64'h3000, 12'h005, 2'd0, 1'b0, 1'b0, 64'h55555555_555555AB, 5'd4, 64'h0,
       64'h3005, 64'hABABABAB_ABABABAB, 8'h20, 64'h0, 1'b0);
    idle(5);
    dm_req_ready = 1'b1;
    idle(6);

    // Fill the tracker with responses withheld.
    resp_en = 1'b0;
    hs0 = dm_hs;
    fork
      for (int i = 0; i < 6; i++)
        op(0, 64'h200 + 64'(4 * i), 64'h4000, 12'(8 * i), 2'd3, 1'b0, 1'b1, 64'h0, 5'(i + 12),
           64'h11111111_11111111 * 64'(i + 1), 64'h4000 + 64'(8 * i), 64'h0, 8'h0,
           64'h11111111_11111111 * 64'(i + 1), 1'b0);
      begin
        repeat (20) @(negedge clk);
        chk("full_dm_hs", 64'(dm_hs - hs0), 64'd4);
        chk("full_ix_ready", 64'(ix_lsp_ready), 64'd0);
        chk("full_dm_valid", 64'(dm_req_valid), 64'd0);
        chk("full_wb_valid", 64'(lsp_wb_valid), 64'd0);
        chk("full_busy", 64'(lsp_ix_mem_busy), 64'd1);
        resp_en = 1'b1;
      end
    join
    idle(12);
    chk("drain_dm_hs", 64'(dm_hs - hs0), 64'd6);

    // Misaligned accesses raise a one-cycle exception; abort drops everything.
    op(1, 64'h80, 64'h3000, 12'h003, 2'd3, 1'b0, 1'b1, 64'h0, 5'd1, 64'h0, 64'h0, 64'h0, 8'h0, 64'h0, 1'b0);
    op(1, 64'h84, 64'h3000, 12'h002, 2'd2, 1'b0, 1'b0, 64'h0, 5'd1, 64'h0, 64'h0, 64'h0, 8'h0, 64'h0, 1'b0);
    op(1, 64'h88, 64'h3000, 12'h001, 2'd1, 1'b0, 1'b1, 64'h0, 5'd1, 64'h0, 64'h0, 64'h0, 8'h0, 64'h0, 1'b0);
    op(2, 64'h80, 64'h3000, 12'h003, 2'd3, 1'b0, 1'b1, 64'h0, 5'd1, 64'h0, 64'h0, 64'h0, 8'h0, 64'h0, 1'b0);
    op(2, 64'h8C, 64'h1000, 12'h000, 2'd2, 1'b0, 1'b1, 64'h0, 5'd1, 64'h0, 64'h0, 64'h0, 8'h0, 64'h0, 1'b0);
    @(negedge clk);
    chk("abort_busy", 64'(lsp_ix_mem_busy), 64'd0);
    @(posedge clk); #1;
    idle(4);

    // Writeback stalled with a full tracker, then reset mid-stream.
    lsp_wb_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      op(0, 64'h300 + 64'(4 * i), 64'h5000, 12'(8 * i), 2'd3, 1'b0, 1'b1, 64'h0, 5'(i + 1),
         64'(i), 64'h5000 + 64'(8 * i), 64'h0, 8'h0, 64'(i), 1'b0);
    idle(10);
    @(negedge clk);
    chk("wbstall_wb_valid", 64'(lsp_wb_valid), 64'd1);
    chk("wbstall_dm_valid", 64'(dm_req_valid), 64'd0);
    chk("wbstall_ix_ready", 64'(ix_lsp_ready), 64'd0);
    @(posedge clk); #1;
    flush_reset();
    #1;
    chk("async_rst_wb_valid", 64'(lsp_wb_valid), 64'd0);
    chk("async_rst_busy", 64'(lsp_ix_mem_busy), 64'd0);
    chk("async_rst_dm_valid", 64'(dm_req_valid), 64'd0);
    idle(2);
    rst = 1'b0;
    lsp_wb_ready = 1'b1;
    stray = 1'b1;
    idle(4);
    @(negedge clk);
    chk("stray_wb_valid", 64'(lsp_wb_valid), 64'd0);
    chk("stray_busy", 64'(lsp_ix_mem_busy), 64'd0);
    @(posedge clk); #1;
    op(0, 64'h400, 64'h1000, 12'h004, 2'd2, 1'b1, 1'b1, 64'h0, 5'd20, 64'hDEADBEEF_80000001,
       64'h1004, 64'h0, 8'h0, 64'h00000000_DEADBEEF, 1'b1);
    idle(10);

    chk("dm_q_empty", 64'(dm_q.size()), 64'd0);
    chk("wb_q_empty", 64'(wb_q.size()), 64'd0);
    chk("exc_q_empty", 64'(exc_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsp_nb.md
LSP_NB -- requirements
Module: lsp_nb

Interface
REQ-001 SHALL have parameter XLEN, default 64, data/address width; legal values 32 or 64.
REQ-002 SHALL have parameter DEPTH, default 4, number of tracked in-flight entries; power of two, 2..16.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports dm_req_addr/dm_req_wdata  out  XLEN; dm_req_wmask  out  XLEN/8; dm_req_wen, dm_req_valid  out  1; dm_req_ready  in  1.
REQ-006 SHALL have ports dm_resp_rdata  in  XLEN; dm_resp_valid  in  1; responses arrive in request order, with no ready signal.
REQ-007 SHALL have issue ports ix_lsp_pc, ix_lsp_base, ix_lsp_source  in  XLEN; ix_lsp_dst  in  5; ix_lsp_wb_en  in  1 (1=load, 0=store); ix_lsp_offset  in  12.
REQ-008 SHALL have ports ix_lsp_mem_sign  in  1 (1=zero-extend); ix_lsp_mem_width  in  2 (0 B, 1 H, 2 W, 3 D); ix_lsp_valid  in  1; ix_lsp_ready  out  1.
REQ-009 SHALL have port lsp_ix_mem_busy  out  1  high while the AG register or any tracked entry is occupied.
REQ-010 SHALL have writeback ports lsp_wb_result, lsp_wb_pc  out  XLEN; lsp_wb_dst  out  5; lsp_wb_wb_en, lsp_wb_valid  out  1; lsp_wb_ready  in  1.
REQ-011 SHALL have ports ag_abort  in  1; lsp_unaligned_load, lsp_unaligned_store  out  1; lsp_unaligned_epc  out  XLEN.

Function
REQ-012 Address SHALL be ix_lsp_base plus the sign-extended offset, modulo 2^XLEN.
REQ-013 Misaligned SHALL mean: H with addr[0]!=0; W with addr[1:0]!=0; D with addr[2:0]!=0; D when XLEN=32 is always misaligned.
REQ-014 Issue handshake (ix_lsp_valid && ix_lsp_ready) SHALL load the AG register. ix_lsp_ready = AG empty || AG request accepted by memory this cycle.
REQ-015 Store wdata SHALL replicate the low 8/16/32 bits across XLEN. wmask SHALL select the addressed byte lanes. D/native width SHALL drive an all-ones wmask.
REQ-016 dm_req_* SHALL be registered. dm_req_valid SHALL assert the cycle after handshake. Addr/wdata/wmask/wen SHALL hold stable while valid && !ready.
REQ-017 dm_req_valid SHALL be gated low while DEPTH entries are allocated. No request SHALL issue without a free entry.
REQ-018 Each dm_req handshake SHALL allocate the tail entry (pc, dst, wb_en, byte offset, width, sign) and advance the tail pointer modulo DEPTH.
REQ-019 Each dm_resp_valid SHALL complete the oldest uncompleted entry, storing the aligned, extended result. For a store entry, it SHALL store zero.
REQ-020 Load extension SHALL select the lane by byte offset, then zero- or sign-extend to XLEN per mem_sign. Native width SHALL pass through.
REQ-021 dm_resp_valid with no uncompleted entry SHALL be ignored, with no state change.
REQ-022 lsp_wb_* SHALL present the head entry combinationally; lsp_wb_valid = head completed.
REQ-023 The head SHALL free on lsp_wb_valid && lsp_wb_ready. Free, allocate and complete in one cycle SHALL all take effect.
REQ-024 Minimum latency SHALL be: handshake at cycle t, dm_req at t+1, response at t+2, lsp_wb_valid at t+3.
REQ-025 Misaligned handshake SHALL NOT enter AG. It SHALL pulse lsp_unaligned_load (wb_en=1) or lsp_unaligned_store (wb_en=0) for one cycle at t+1, with epc = pc.
REQ-026 ag_abort high during a handshake SHALL discard that request: no memory request, no exception pulse. ag_abort SHALL have no effect otherwise.
REQ-027 Simultaneous full queue and back-pressure SHALL stall AG without losing or duplicating any request.

Reset
REQ-028 rst SHALL clear AG valid, all pointers and counts, dm_req_valid, lsp_wb_valid, lsp_unaligned_load/store and lsp_ix_mem_busy immediately. Data registers MAY be left unreset.
REQ-029 Responses arriving after reset for requests issued before reset SHALL be ignored per REQ-021.

Verification
REQ-030 LW, XLEN=64, addr 0x1004, rdata 0xDEADBEEF_80000001, sign=0 -> wb_result 0xFFFFFFFF_DEADBEEF at t+3.
REQ-031 SH, source 0x1234, addr 0x2002 -> wdata 0x1234123412341234, wmask 0x0C, wen=1; response -> wb_valid with wb_en=0.
REQ-032 DEPTH=4, dm_resp withheld, 6 back-to-back loads -> exactly 4 dm handshakes, ix_lsp_ready low. Then 4 responses -> in-order writeback, remaining 2 issue.
REQ-033 LD addr 0x3003, pc 0x80 -> no dm_req_valid, lsp_unaligned_load pulse of 1 cycle, epc 0x80. Same request with ag_abort=1 -> no pulse.
REQ-034 lsp_wb_ready=0 with 4 completed entries -> dm_req_valid low. Then rst mid-stream, then stray dm_resp_valid -> lsp_wb_valid stays 0.
